// File: rtl/memory_stage.sv
// memory_stage: memory stage of the Y86-64 pipeline.
// Latches the execute outputs into the M pipeline register and performs
// the data memory load/store for the instruction held in M.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   M_bubble          load a bubble into M instead of the execute outputs
//   wr_inhibit        suppress the store (a later stage holds an exception)
//   e_*               execute stage results (icode, Cnd, valE, valA, dstE, dstM, stat)
//   M_*               M pipeline register contents
//   m_valM            loaded data (0 for non-reads or on error)
//   m_stat            stage status after the memory range check
//   dmem_error        current access is out of range
module memory_stage #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        M_bubble,
  input  logic        wr_inhibit,
  input  logic [3:0]  e_icode,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic [2:0]  e_stat,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [2:0]  M_stat,
  output logic [63:0] m_valM,
  output logic [2:0]  m_stat,
  output logic        dmem_error
);

  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_BYTES - 8);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  logic [3:0]  icode_q, icode_d;
  logic        cnd_q, cnd_d;
  logic [63:0] val_e_q, val_e_d;
  logic [63:0] val_a_q, val_a_d;
  logic [3:0]  dst_e_q, dst_e_d;
  logic [3:0]  dst_m_q, dst_m_d;
  logic [2:0]  stat_q, stat_d;

  logic [7:0]  mem [MEM_BYTES];

  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  base;
  logic              rd_en, wr_sel, acc_err, wr_en;
  logic [63:0]       rd_data;

  always_comb begin
    if (M_bubble) begin
      icode_d = I_NOP;
      cnd_d   = 1'b0;
      val_e_d = '0;
      val_a_d = '0;
      dst_e_d = R_NONE;
      dst_m_d = R_NONE;
      stat_d  = STAT_AOK;
    end else begin
      icode_d = e_icode;
      cnd_d   = e_Cnd;
      val_e_d = e_valE;
      val_a_d = e_valA;
      dst_e_d = e_dstE;
      dst_m_d = e_dstM;
      stat_d  = e_stat;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      icode_q <= I_NOP;
      cnd_q   <= 1'b0;
      val_e_q <= '0;
      val_a_q <= '0;
      dst_e_q <= R_NONE;
      dst_m_q <= R_NONE;
      stat_q  <= STAT_AOK;
    end else begin
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      val_e_q <= val_e_d;
      val_a_q <= val_a_d;
      dst_e_q <= dst_e_d;
      dst_m_q <= dst_m_d;
      stat_q  <= stat_d;
    end
  end

  // ret/popq address through the old stack pointer (valA); the rest use valE.
  always_comb begin
    rd_en  = (icode_q == I_MRMOVQ) || (icode_q == I_RET) || (icode_q == I_POPQ);
    wr_sel = (icode_q == I_RMMOVQ) || (icode_q == I_CALL) || (icode_q == I_PUSHQ);
    if ((icode_q == I_RET) || (icode_q == I_POPQ)) begin
      addr = ADDR_W'(val_a_q);
    end else begin
      addr = ADDR_W'(val_e_q);
    end
  end

  // Full-width compare: huge addresses must fault, never alias low memory.
  assign acc_err = (rd_en || wr_sel) && (addr > ADDR_LIMIT);
  assign base    = addr[IDX_W-1:0];
  assign wr_en   = wr_sel && !acc_err && (stat_q == STAT_AOK) && !wr_inhibit && !reset;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 8; i++) begin
      rd_data[8*i +: 8] = mem[base + IDX_W'(i)];
    end
  end

  // Memory has no reset: contents survive a pipeline reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + IDX_W'(i)] <= val_a_q[8*i +: 8];
      end
    end
  end

  assign M_icode    = icode_q;
  assign M_Cnd      = cnd_q;
  assign M_valE     = val_e_q;
  assign M_valA     = val_a_q;
  assign M_dstE     = dst_e_q;
  assign M_dstM     = dst_m_q;
  assign M_stat     = stat_q;
  assign dmem_error = acc_err;
  assign m_valM     = (rd_en && !acc_err) ? rd_data : 64'd0;
  assign m_stat     = acc_err ? STAT_ADR : stat_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboarded bench for memory_stage: each issued instruction pushes the
// expected M-cycle outputs; a negedge monitor pops and compares them.
module tb_memory_stage;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;
  localparam logic [3:0] NOP = 4'h1, RMM = 4'h4, MRM = 4'h5, CALL = 4'h8;
  localparam logic [3:0] RET = 4'h9, PUSH = 4'hA, POP = 4'hB, RN = 4'hF;

  logic        clock = 1'b0;
  logic        reset, M_bubble, wr_inhibit;
  logic [3:0]  e_icode, e_dstE, e_dstM;
  logic        e_Cnd;
  logic [63:0] e_valE, e_valA;
  logic [2:0]  e_stat;
  logic [3:0]  M_icode, M_dstE, M_dstM;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA, m_valM;
  logic [2:0]  M_stat, m_stat;
  logic        dmem_error;

  memory_stage #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
    .clock(clock), .reset(reset), .M_bubble(M_bubble), .wr_inhibit(wr_inhibit),
    .e_icode(e_icode), .e_Cnd(e_Cnd), .e_valE(e_valE), .e_valA(e_valA),
    .e_dstE(e_dstE), .e_dstM(e_dstM), .e_stat(e_stat),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat),
    .m_valM(m_valM), .m_stat(m_stat), .dmem_error(dmem_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          id;
    int          cyc;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [2:0]  stat;
    logic [63:0] val_m;
    logic [2:0]  mstat;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int step_id = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Drive one instruction for the cycle ending at the next edge. The
  // control inputs (inh, rst) act on whatever is already in M.
  task automatic step(input logic [3:0] icode, input logic [63:0] val_e,
                      input logic [63:0] val_a, input logic [3:0] dst_e,
                      input logic [3:0] dst_m, input logic [2:0] stat,
                      input logic bub, input logic inh, input logic rst,
                      input logic [63:0] x_val_m, input logic [2:0] x_mstat,
                      input logic x_err);
    exp_t e;
    e_icode = icode; e_Cnd = 1'b1; e_valE = val_e; e_valA = val_a;
    e_dstE = dst_e; e_dstM = dst_m; e_stat = stat;
    M_bubble = bub; wr_inhibit = inh; reset = rst;
    step_id++;
    e.id = step_id;
    e.cyc = cyc + 1;
    if (bub || rst) begin
      e.icode = NOP; e.cnd = 1'b0; e.val_e = '0; e.val_a = '0;
      e.dst_e = RN; e.dst_m = RN; e.stat = AOK;
    end else begin
      e.icode = icode; e.cnd = 1'b1; e.val_e = val_e; e.val_a = val_a;
      e.dst_e = dst_e; e.dst_m = dst_m; e.stat = stat;
    end
    e.val_m = x_val_m; e.mstat = x_mstat; e.err = x_err;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (e.cyc != cyc || M_icode !== e.icode || M_Cnd !== e.cnd ||
            M_valE !== e.val_e || M_valA !== e.val_a || M_dstE !== e.dst_e ||
            M_dstM !== e.dst_m || M_stat !== e.stat || m_valM !== e.val_m ||
            m_stat !== e.mstat || dmem_error !== e.err) begin
          n_fail++;
          $display("FAIL step%0d cyc=%0d/%0d: got icode=%h cnd=%b valE=%h valA=%h dstE=%h dstM=%h stat=%0d valM=%h mstat=%0d err=%b; want icode=%h cnd=%b valE=%h valA=%h dstE=%h dstM=%h stat=%0d valM=%h mstat=%0d err=%b",
                   e.id, cyc, e.cyc, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
                   M_stat, m_valM, m_stat, dmem_error, e.icode, e.cnd, e.val_e,
                   e.val_a, e.dst_e, e.dst_m, e.stat, e.val_m, e.mstat, e.err);
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1; M_bubble = 1'b0; wr_inhibit = 1'b0;
    e_icode = NOP; e_Cnd = 1'b0; e_valE = '0; e_valA = '0;
    e_dstE = RN; e_dstM = RN; e_stat = AOK;

    //   icode  valE                   valA                   dstE dstM stat bub inh rst  exp valM               mstat err
    // reset with a store presented: M must come up as a bubble
    step(RMM,  64'h10,                64'h99,                RN,  RN,  AOK, 0,  0,  1,   64'h0,                 AOK, 0);
    // clear 0x18..0x1F, then store and read back next cycle
    step(RMM,  64'h18,                64'h0,                 RN,  RN,  AOK, 0,  0,  0,   64'h0,                 AOK, 0);
    step(RMM,  64'h10,                64'h0123456789ABCDEF,  RN,  RN,  AOK, 0,  0,  0,   64'h0,                 AOK, 0);
    step(MRM,  64'h10,                64'h0,                 RN,  4'h3, AOK, 0, 0,  0,   64'h0123456789ABCDEF,  AOK, 0);
    step(MRM,  64'h11,                64'h0,                 RN,  4'h3, AOK, 0, 0,  0,   64'h000123456789ABCD,  AOK, 0);
    // stack ops: push/pop, call/ret
    step(PUSH, 64'h1F8,               64'h55,                4'h4, RN,  AOK, 0,  0,  0,   64'h0,                 AOK, 0);
    step(POP,  64'h200,               64'h1F8,               4'h4, 4'h0, AOK, 0, 0,  0,   64'h55,                AOK, 0);
    step(CALL, 64'h1F0,               64'h123,               4'h4, RN,  AOK, 0,  0,  0,   64'h0,                 AOK, 0);
    step(RET,  64'h1F8,               64'h1F0,               4'h4, RN,  AOK, 0,  0,  0,   64'h123,               AOK, 0);
    // highest legal address, then one past it
    step(RMM,  64'h3F8,               64'hCAFEF00DDEADBEEF,  RN,  RN,  AOK, 0,  0,  0,   64'h0,                 AOK, 0);
    step(RMM,  64'h3F9,               64'h1111111111111111,  RN,  RN,  AOK, 0,  0,  0,   64'h0,                 ADR, 1);
    step(MRM,  64'h3F8,               64'h0,                 RN,  4'h3, AOK, 0, 0,  0,   64'hCAFEF00DDEADBEEF,  AOK, 0);
    step(MRM,  64'hFFFF_FFFF_FFFF_FFFC, 64'h0,               RN,  4'h3, AOK, 0, 0,  0,   64'h0,                 ADR, 1);
    // inhibited store and non-AOK store leave 0x20 holding 0x77
    step(RMM,  64'h20,                64'h77,                RN,  RN,  AOK, 0,  0,  0,   64'h0,                 AOK, 0);
    step(RMM,  64'h20,                64'hAAAA,              RN,  RN,  AOK, 0,  0,  0,   64'h0,                 AOK, 0);
    step(NOP,  64'h0,                 64'h0,                 RN,  RN,  AOK, 0,  1,  0,   64'h0,                 AOK, 0);
    step(RMM,  64'h20,                64'hBBBB,              RN,  RN,  INS, 0,  0,  0,   64'h0,                 INS, 0);
    step(MRM,  64'h20,                64'h0,                 RN,  4'h3, AOK, 0, 0,  0,   64'h77,                AOK, 0);
    // bubble over a store
    step(RMM,  64'h20,                64'hCCCC,              4'h2, 4'h3, AOK, 1, 0,  0,   64'h0,                 AOK, 0);
    step(MRM,  64'h20,                64'h0,                 RN,  4'h3, AOK, 0, 0,  0,   64'h77,                AOK, 0);
    // reset while a store sits in M
    step(RMM,  64'h10,                64'hDEAD,              RN,  RN,  AOK, 0,  0,  0,   64'h0,                 AOK, 0);
    step(RMM,  64'h10,                64'hBEEF,              RN,  RN,  AOK, 0,  0,  1,   64'h0,                 AOK, 0);
    step(MRM,  64'h10,                64'h0,                 RN,  4'h3, AOK, 0, 0,  0,   64'h0123456789ABCDEF,  AOK, 0);
    step(NOP,  64'h0,                 64'h0,                 RN,  RN,  AOK, 0,  0,  0,   64'h0,                 AOK, 0);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clock);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries never checked, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
